// File: rtl/mbist_sti_seq_pkg.sv
// Shared types and constants for the MBIST stimulus sequencer.
package mbist_sti_seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } sti_state_e;

    // Run modes held in the two LSBs of the configuration chain; 2'b11 runs as SEQ.
    localparam logic [1:0] MODE_SEQ    = 2'b00;
    localparam logic [1:0] MODE_LOOP   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    // Default 8-entry stimulus table, 15-bit words.
    localparam int unsigned STI_DEF_WD  = 15;
    localparam int unsigned STI_DEF_CNT = 8;

    localparam logic [STI_DEF_WD-1:0] STI_DEF_0 = 15'h0001;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_1 = 15'h0a12;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_2 = 15'h1523;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_3 = 15'h2034;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_4 = 15'h2b45;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_5 = 15'h3656;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_6 = 15'h4167;
    localparam logic [STI_DEF_WD-1:0] STI_DEF_7 = 15'h7c78;

    // Entry i sits at bits [i*WD +: WD].
    localparam logic [STI_DEF_CNT*STI_DEF_WD-1:0] STI_TABLE_DEF = {
        STI_DEF_7, STI_DEF_6, STI_DEF_5, STI_DEF_4,
        STI_DEF_3, STI_DEF_2, STI_DEF_1, STI_DEF_0
    };

endpackage

// File: rtl/mbist_sti_seq_if.sv
// Handshake between the MBIST operation FSM (master) and the stimulus sequencer (slave).
interface mbist_sti_seq_if #(
    parameter int unsigned STI_WD = 15,
    parameter int unsigned IDX_WD = 3
);
    logic              start;
    logic              sti_next;
    logic              sti_vld;
    logic [STI_WD-1:0] stimulus;
    logic [IDX_WD-1:0] sti_idx;
    logic              last_stimulus;
    logic              done;
    logic              empty_err;

    modport master (
        output start,
        output sti_next,
        input  sti_vld,
        input  stimulus,
        input  sti_idx,
        input  last_stimulus,
        input  done,
        input  empty_err
    );

    modport slave (
        input  start,
        input  sti_next,
        output sti_vld,
        output stimulus,
        output sti_idx,
        output last_stimulus,
        output done,
        output empty_err
    );
endinterface

// File: rtl/mbist_sti_pick.sv
// Combinational enabled-index search over the stimulus enable mask.
module mbist_sti_pick #(
    parameter int unsigned BIST_STI_CNT = 8,
    parameter int unsigned BIST_IDX_WD  = $clog2(BIST_STI_CNT)
) (
    input  logic [BIST_STI_CNT-1:0] i_en_mask,
    input  logic [BIST_IDX_WD-1:0]  i_cur_idx,
    output logic [BIST_IDX_WD-1:0]  o_first_idx,
    output logic [BIST_IDX_WD-1:0]  o_next_idx,
    output logic                    o_has_next,
    output logic                    o_mask_empty
);

    // Lowest enabled index; scanning downward lets the lowest hit win.
    always_comb begin
        o_first_idx = '0;
        for (int i = BIST_STI_CNT - 1; i >= 0; i--) begin
            if (i_en_mask[i]) begin
                o_first_idx = BIST_IDX_WD'(i);
            end
        end
    end

    // Lowest enabled index strictly above the current one.
    always_comb begin
        o_next_idx = '0;
        o_has_next = 1'b0;
        for (int i = BIST_STI_CNT - 1; i >= 0; i--) begin
            if (i_en_mask[i] && (i > int'(i_cur_idx))) begin
                o_next_idx = BIST_IDX_WD'(i);
                o_has_next = 1'b1;
            end
        end
    end

    assign o_mask_empty = ~|i_en_mask;

endmodule

// File: rtl/mbist_sti_seq.sv
// MBIST stimulus sequencer: scan-loaded config, walks enabled table entries on start/next.
module mbist_sti_seq
    import mbist_sti_seq_pkg::*;
#(
    parameter int unsigned BIST_STI_WD  = 15,
    parameter int unsigned BIST_STI_CNT = 8,
    parameter int unsigned BIST_IDX_WD  = $clog2(BIST_STI_CNT),
    parameter int unsigned BIST_REP_WD  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_scan_shift,
    input  logic                                i_sdi,
    output logic                                o_sdo,
    input  logic [BIST_STI_CNT*BIST_STI_WD-1:0] i_sti_table,
    mbist_sti_seq_if.slave                      io_seq
);

    // Chain layout, LSB first: {mode[1:0], rep, en_mask}.
    localparam int unsigned CHAIN_LEN = BIST_STI_CNT + BIST_REP_WD + 2;
    localparam logic [CHAIN_LEN-1:0] CHAIN_RST = {{BIST_STI_CNT{1'b1}}, {(BIST_REP_WD + 2){1'b0}}};

    logic [CHAIN_LEN-1:0]    r_chain;
    logic [1:0]              w_mode;
    logic [BIST_REP_WD-1:0]  w_rep;
    logic [BIST_STI_CNT-1:0] w_en_mask;

    sti_state_e              r_state;
    sti_state_e              w_state_nxt;
    logic [BIST_IDX_WD-1:0]  r_cur_idx;
    logic [BIST_IDX_WD-1:0]  w_idx_nxt;
    logic [BIST_REP_WD-1:0]  r_pass_cnt;
    logic [BIST_REP_WD-1:0]  w_pass_nxt;
    logic                    r_empty_err;
    logic                    w_err_nxt;

    logic [BIST_IDX_WD-1:0]  w_first_idx;
    logic [BIST_IDX_WD-1:0]  w_next_idx;
    logic                    w_has_next;
    logic                    w_mask_empty;
    logic                    w_is_rep;
    logic                    w_is_single;
    logic                    w_adv;

    logic [BIST_STI_WD-1:0]  w_sti_tbl [BIST_STI_CNT];

    assign w_mode    = r_chain[1:0];
    assign w_rep     = r_chain[2 +: BIST_REP_WD];
    assign w_en_mask = r_chain[2 + BIST_REP_WD +: BIST_STI_CNT];
    assign o_sdo     = r_chain[0];

    // Only LOOP and SINGLE consume the pass count; SEQ and 2'b11 run once.
    assign w_is_single = (w_mode == MODE_SINGLE);
    assign w_is_rep    = (w_mode == MODE_LOOP) || w_is_single;
    // SINGLE never steps upward, so a higher enabled index does not count as "next".
    assign w_adv       = w_has_next && !w_is_single;

    for (genvar g = 0; g < BIST_STI_CNT; g++) begin : g_tbl
        assign w_sti_tbl[g] = i_sti_table[g*BIST_STI_WD +: BIST_STI_WD];
    end

    mbist_sti_pick #(
        .BIST_STI_CNT (BIST_STI_CNT),
        .BIST_IDX_WD  (BIST_IDX_WD)
    ) u_pick (
        .i_en_mask    (w_en_mask),
        .i_cur_idx    (r_cur_idx),
        .o_first_idx  (w_first_idx),
        .o_next_idx   (w_next_idx),
        .o_has_next   (w_has_next),
        .o_mask_empty (w_mask_empty)
    );

    // Configuration chain: shifts toward bit 0 with sdi entering at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= CHAIN_RST;
        end else if (i_scan_shift) begin
            r_chain <= {i_sdi, r_chain[CHAIN_LEN-1:1]};
        end
    end

    // State register together with the index, pass counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cur_idx   <= '0;
            r_pass_cnt  <= '0;
            r_empty_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_idx   <= w_idx_nxt;
            r_pass_cnt  <= w_pass_nxt;
            r_empty_err <= w_err_nxt;
        end
    end

    // Next state: scan_shift beats start, start beats sti_next.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_cur_idx;
        w_pass_nxt  = r_pass_cnt;
        w_err_nxt   = r_empty_err;
        if (i_scan_shift) begin
            w_state_nxt = StIdle;
            w_err_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (io_seq.start) begin
                        w_err_nxt = w_mask_empty;
                        if (w_mask_empty) begin
                            w_state_nxt = StDone;
                        end else begin
                            w_state_nxt = StActive;
                            w_idx_nxt   = w_first_idx;
                            w_pass_nxt  = w_is_rep ? w_rep : '0;
                        end
                    end
                end
                StActive: begin
                    if (io_seq.sti_next) begin
                        if (w_adv) begin
                            w_idx_nxt = w_next_idx;
                        end else if (r_pass_cnt != '0) begin
                            w_idx_nxt  = w_first_idx;
                            w_pass_nxt = r_pass_cnt - BIST_REP_WD'(1);
                        end else begin
                            w_state_nxt = StDone;
                        end
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; stimulus is a plain table mux.
    always_comb begin
        io_seq.sti_vld       = (r_state == StActive);
        io_seq.done          = (r_state == StDone);
        io_seq.empty_err     = r_empty_err;
        io_seq.sti_idx       = r_cur_idx;
        io_seq.stimulus      = w_sti_tbl[r_cur_idx];
        io_seq.last_stimulus = (r_state == StActive) && !w_adv &&
                               ((r_pass_cnt == '0) || !w_is_rep);
    end

endmodule
